// File: rtl/cr_ram_rd_arbiter_if.sv
// Bundled address-request, RAM-read and response streams for cr_ram_rd_arbiter.
// master = requester/RAM side, slave = the arbiter itself.
interface cr_ram_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] req0_tdata;
  logic              req0_tvalid;
  logic              req0_tready;
  logic [ADDR_W-1:0] req1_tdata;
  logic              req1_tvalid;
  logic              req1_tready;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [DATA_W-1:0] rsp0_tdata;
  logic              rsp0_tvalid;
  logic              rsp0_tready;
  logic [DATA_W-1:0] rsp1_tdata;
  logic              rsp1_tvalid;
  logic              rsp1_tready;
  logic              busy;

  modport master (
    output req0_tdata, req0_tvalid, req1_tdata, req1_tvalid, ram_rd_data,
    output rsp0_tready, rsp1_tready,
    input  req0_tready, req1_tready, ram_rd_en, ram_rd_addr,
    input  rsp0_tdata, rsp0_tvalid, rsp1_tdata, rsp1_tvalid, busy
  );

  modport slave (
    input  req0_tdata, req0_tvalid, req1_tdata, req1_tvalid, ram_rd_data,
    input  rsp0_tready, rsp1_tready,
    output req0_tready, req1_tready, ram_rd_en, ram_rd_addr,
    output rsp0_tdata, rsp0_tvalid, rsp1_tdata, rsp1_tvalid, busy
  );
endinterface

// File: rtl/cr_ram_rd_arbiter.sv
// Round-robin sharing of one RAM read port between two credited requesters with in-order
// FWFT response FIFOs. Define CR_RD_ARB_STAT_EN to add saturating grant/stall counters.
module cr_ram_rd_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset_p,
  cr_ram_rd_arbiter_if.slave bus
`ifdef CR_RD_ARB_STAT_EN
  ,
  output logic [15:0]        stat_gnt0,
  output logic [15:0]        stat_gnt1,
  output logic [15:0]        stat_stall0,
  output logic [15:0]        stat_stall1
`endif
);

  localparam int unsigned     PtrW     = $clog2(RSP_DEPTH);
  localparam int unsigned     CntW     = PtrW + 1;
  localparam logic [CntW-1:0] Full     = CntW'(RSP_DEPTH);
  localparam logic [ADDR_W-1:0] IdleAddr = '0;

  logic                  rst_dly_q;
  logic                  last_grant_q;
  logic [CntW-1:0]       credit_q [2];
  logic [CntW-1:0]       cnt_q    [2];
  logic [PtrW-1:0]       wr_ptr_q [2];
  logic [PtrW-1:0]       rd_ptr_q [2];
  logic [DATA_W-1:0]     mem_q    [2][RSP_DEPTH];
  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [RD_LATENCY-1:0] tag_id_q;

  logic [1:0] req_vld, rsp_rdy, elig, grant, rsp_vld, pop, push;
  logic       tag_out_vld, tag_out_id;

  assign req_vld     = {bus.req1_tvalid, bus.req0_tvalid};
  assign rsp_rdy     = {bus.rsp1_tready, bus.rsp0_tready};
  assign tag_out_vld = tag_vld_q[RD_LATENCY-1];
  assign tag_out_id  = tag_id_q[RD_LATENCY-1];

  // Requests are masked during reset and the cycle after it.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      elig[r]    = req_vld[r] && (credit_q[r] != '0) && !reset_p && !rst_dly_q;
      rsp_vld[r] = (cnt_q[r] != '0) && !reset_p;
      pop[r]     = rsp_vld[r] && rsp_rdy[r];
      push[r]    = tag_out_vld && (tag_out_id == 1'(r));
    end
    grant = elig;
    if (elig == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
  end

  assign bus.req0_tready = grant[0];
  assign bus.req1_tready = grant[1];
  assign bus.ram_rd_en   = |grant;
  assign bus.ram_rd_addr = grant[0] ? bus.req0_tdata :
                           grant[1] ? bus.req1_tdata : IdleAddr;
  assign bus.rsp0_tvalid = rsp_vld[0];
  assign bus.rsp1_tvalid = rsp_vld[1];
  assign bus.rsp0_tdata  = mem_q[0][rd_ptr_q[0]];
  assign bus.rsp1_tdata  = mem_q[1][rd_ptr_q[1]];
  assign bus.busy        = ((|tag_vld_q) || (cnt_q[0] != '0) || (cnt_q[1] != '0)) && !reset_p;

  always_ff @(posedge clk) begin
    rst_dly_q <= reset_p;
    if (reset_p) begin
      last_grant_q <= 1'b1;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      for (int r = 0; r < 2; r++) begin
        credit_q[r] <= Full;
        cnt_q[r]    <= '0;
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
      end
    end else begin
      if (|grant) last_grant_q <= grant[1];
      tag_vld_q[0] <= |grant;
      tag_id_q[0]  <= grant[1];
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      for (int r = 0; r < 2; r++) begin
        credit_q[r] <= credit_q[r] + CntW'(pop[r]) - CntW'(grant[r]);
        cnt_q[r]    <= cnt_q[r] + CntW'(push[r]) - CntW'(pop[r]);
        if (push[r]) wr_ptr_q[r] <= wr_ptr_q[r] + PtrW'(1);
        if (pop[r])  rd_ptr_q[r] <= rd_ptr_q[r] + PtrW'(1);
        assert (!(push[r] && cnt_q[r] == Full));
        assert (credit_q[r] <= Full);
        assert (!(grant[r] && credit_q[r] == '0));
        assert (!(pop[r] && credit_q[r] == Full));
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (!reset_p && push[r]) mem_q[r][wr_ptr_q[r]] <= bus.ram_rd_data;
    end
  end

`ifdef CR_RD_ARB_STAT_EN
  logic [15:0] stat_gnt_q   [2];
  logic [15:0] stat_stall_q [2];

  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (reset_p) begin
        stat_gnt_q[r]   <= '0;
        stat_stall_q[r] <= '0;
      end else begin
        if (grant[r] && stat_gnt_q[r] != 16'hFFFF) stat_gnt_q[r] <= stat_gnt_q[r] + 16'd1;
        if (req_vld[r] && !grant[r] && stat_stall_q[r] != 16'hFFFF) begin
          stat_stall_q[r] <= stat_stall_q[r] + 16'd1;
        end
      end
    end
  end

  assign stat_gnt0   = stat_gnt_q[0];
  assign stat_gnt1   = stat_gnt_q[1];
  assign stat_stall0 = stat_stall_q[0];
  assign stat_stall1 = stat_stall_q[1];
`endif

endmodule

// File: tb/tb_cr_ram_rd_arbiter.sv
// Self-checking bench for cr_ram_rd_arbiter: directed scenarios plus a randomized run, all
// compared every cycle against a queue-based model of grants, credits and responses.
module tb_cr_ram_rd_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned L  = 1;
  localparam int unsigned D  = 4;

  logic clk = 1'b0;
  logic reset_p;
  always #5 clk = ~clk;

  cr_ram_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef CR_RD_ARB_STAT_EN
  logic [15:0] stat_gnt0, stat_gnt1, stat_stall0, stat_stall1;
`endif

  cr_ram_rd_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RD_LATENCY(L),
    .RSP_DEPTH (D)
  ) dut (
    .clk    (clk),
    .reset_p(reset_p),
    .bus    (bus)
`ifdef CR_RD_ARB_STAT_EN
    ,
    .stat_gnt0  (stat_gnt0),
    .stat_gnt1  (stat_gnt1),
    .stat_stall0(stat_stall0),
    .stat_stall1(stat_stall1)
`endif
  );

  // RAM model preloaded with {A5, addr}, L-cycle read latency.
  logic [DW-1:0] ram      [256];
  logic [DW-1:0] ram_pipe [L];
  initial for (int a = 0; a < 256; a++) ram[a] = {8'hA5, 8'(a)};
  always @(posedge clk) begin
    if (bus.ram_rd_en) ram_pipe[0] <= ram[bus.ram_rd_addr];
    for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign bus.ram_rd_data = ram_pipe[L-1];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor state (observations of the DUT used by the directed checks).
  int            cyc_n = 0;
  logic          acc0 = 1'b0, acc1 = 1'b0;
  int            gcnt0 = 0, gcnt1 = 0;
  int            gseq[$];
  logic [15:0]   log0[$], log1[$];
  int            first_acc0 = -1, last_acc0 = -1, first_vld0 = -1;

  // Model: per-requester queue of outstanding reads (in flight + buffered) with ready cycle.
  logic [15:0]   mq0_dat[$], mq1_dat[$];
  int            mq0_rdy[$], mq1_rdy[$];
  int            ecyc = 0;
  logic          m_last = 1'b1;
  logic          m_post = 1'b0;
  logic          s_rst, e0, e1, g0, g1, rv0, rv1, p0, p1;
  logic [7:0]    ea;

  always begin
    @(negedge clk);
    cyc_n++;
    s_rst = reset_p;
    e0 = bus.req0_tvalid && (mq0_dat.size() < D) && !s_rst && !m_post;
    e1 = bus.req1_tvalid && (mq1_dat.size() < D) && !s_rst && !m_post;
    if (e0 && e1) begin
      g0 = m_last;
      g1 = !m_last;
    end else begin
      g0 = e0;
      g1 = e1;
    end
    ea  = g0 ? bus.req0_tdata : (g1 ? bus.req1_tdata : 8'h00);
    rv0 = !s_rst && (mq0_dat.size() != 0) && (mq0_rdy[0] <= ecyc);
    rv1 = !s_rst && (mq1_dat.size() != 0) && (mq1_rdy[0] <= ecyc);
    chk("req0_tready", bus.req0_tready, g0);
    chk("req1_tready", bus.req1_tready, g1);
    chk("ram_rd_en", bus.ram_rd_en, g0 | g1);
    chk("ram_rd_addr", bus.ram_rd_addr, ea);
    chk("rsp0_tvalid", bus.rsp0_tvalid, rv0);
    chk("rsp1_tvalid", bus.rsp1_tvalid, rv1);
    if (rv0) chk("rsp0_tdata", bus.rsp0_tdata, mq0_dat[0]);
    if (rv1) chk("rsp1_tdata", bus.rsp1_tdata, mq1_dat[0]);
    chk("busy", bus.busy, !s_rst && (mq0_dat.size() + mq1_dat.size() != 0));
    p0 = rv0 && bus.rsp0_tready;
    p1 = rv1 && bus.rsp1_tready;

    acc0 = bus.req0_tvalid && bus.req0_tready;
    acc1 = bus.req1_tvalid && bus.req1_tready;
    if (bus.req0_tready) begin
      gcnt0++;
      gseq.push_back(0);
      if (first_acc0 < 0) first_acc0 = cyc_n;
      last_acc0 = cyc_n;
    end
    if (bus.req1_tready) begin
      gcnt1++;
      gseq.push_back(1);
    end
    if (bus.rsp0_tvalid && first_vld0 < 0) first_vld0 = cyc_n;
    if (bus.rsp0_tvalid && bus.rsp0_tready) log0.push_back(bus.rsp0_tdata);
    if (bus.rsp1_tvalid && bus.rsp1_tready) log1.push_back(bus.rsp1_tdata);

    @(posedge clk);
    ecyc++;
    if (s_rst) begin
      mq0_dat.delete(); mq0_rdy.delete(); mq1_dat.delete(); mq1_rdy.delete();
      m_last = 1'b1;
      m_post = 1'b1;
    end else begin
      m_post = 1'b0;
      if (p0) begin void'(mq0_dat.pop_front()); void'(mq0_rdy.pop_front()); end
      if (p1) begin void'(mq1_dat.pop_front()); void'(mq1_rdy.pop_front()); end
      if (g0) begin mq0_dat.push_back({8'hA5, ea}); mq0_rdy.push_back(ecyc + L); end
      if (g1) begin mq1_dat.push_back({8'hA5, ea}); mq1_rdy.push_back(ecyc + L); end
      if (g0) m_last = 1'b0;
      else if (g1) m_last = 1'b1;
    end
  end

  // Stimulus: all input changes happen 1 time unit after a rising edge.
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00, end0 = 8'h00;
  logic       lim0 = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (acc0) begin
      addr0 = addr0 + 8'd1;
      if (lim0 && addr0 == end0) bus.req0_tvalid = 1'b0;
    end
    if (acc1) addr1 = addr1 + 8'd1;
    bus.req0_tdata = addr0;
    bus.req1_tdata = addr1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.busy && k < 100);
    chk({nm, "_drain"}, bus.busy, 1'b0);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_p = 1'b1;
    bus.req0_tvalid = 1'b0; bus.req1_tvalid = 1'b0;
    bus.req0_tdata  = '0;   bus.req1_tdata  = '0;
    bus.rsp0_tready = 1'b0; bus.rsp1_tready = 1'b0;
    repeat (3) cyc();

    // A: requester 0 alone, 0x00..0x0F back to back; tvalid already high in post-reset cycle.
    reset_p = 1'b0;
    addr0 = 8'h00; bus.req0_tdata = addr0; bus.req0_tvalid = 1'b1;
    lim0 = 1'b1; end0 = 8'h10;
    bus.rsp0_tready = 1'b1; bus.rsp1_tready = 1'b1;
    gcnt0 = 0; first_acc0 = -1; first_vld0 = -1; log0.delete();
    @(negedge clk);
    chk("a_post_rst_tready0", bus.req0_tready, 1'b0);
    chk("a_post_rst_busy", bus.busy, 1'b0);
    for (int i = 0; i < 40 && bus.req0_tvalid; i++) cyc();
    wait_idle("a");
    chk("a_grants", gcnt0, 16);
    chk("a_back_to_back", last_acc0 - first_acc0, 15);
    chk("a_latency", first_vld0 - first_acc0, 2);
    chk("a_rsp_count", log0.size(), 16);
    for (int i = 0; i < 16; i++) if (i < log0.size()) chk("a_rsp_data", log0[i], 16'hA500 + i);

    // B: both requesters continuously valid after a fresh reset.
    lim0 = 1'b0;
    bus.req0_tvalid = 1'b0;
    reset_p = 1'b1;
    cyc();
    reset_p = 1'b0;
    cyc();
    addr0 = 8'h10; addr1 = 8'h20;
    bus.req0_tdata = addr0; bus.req1_tdata = addr1;
    bus.req0_tvalid = 1'b1; bus.req1_tvalid = 1'b1;
    gcnt0 = 0; gcnt1 = 0; gseq.delete(); log0.delete(); log1.delete();
    repeat (20) cyc();
    bus.req0_tvalid = 1'b0; bus.req1_tvalid = 1'b0;
`ifdef CR_RD_ARB_STAT_EN
    @(negedge clk);
    chk("b_stat_gnt0", stat_gnt0, 10);
    chk("b_stat_gnt1", stat_gnt1, 10);
    chk("b_stat_stall0", stat_stall0, 10);
    chk("b_stat_stall1", stat_stall1, 10);
`endif
    wait_idle("b");
    for (int i = 0; i < 4; i++) if (i < gseq.size()) chk("b_alternate", gseq[i], i % 2);
    chk("b_gnt0", gcnt0, 10);
    chk("b_gnt1", gcnt1, 10);
    chk("b_rsp0_count", log0.size(), 10);
    chk("b_rsp1_count", log1.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < log0.size()) chk("b_rsp0_order", log0[i], 16'hA510 + i);
      if (i < log1.size()) chk("b_rsp1_order", log1[i], 16'hA520 + i);
    end

    // C: requester 0 consumer stalled; credits cap its grants at D.
    bus.rsp0_tready = 1'b0; bus.rsp1_tready = 1'b1;
    bus.req0_tvalid = 1'b1; bus.req1_tvalid = 1'b1;
    gcnt0 = 0; gcnt1 = 0;
    repeat (10) cyc();
    chk("c_gnt0_capped", gcnt0, D);
    gcnt0 = 0; gcnt1 = 0;
    repeat (8) cyc();
    chk("c_gnt0_masked", gcnt0, 0);
    chk("c_gnt1_full_rate", gcnt1, 8);
    bus.rsp0_tready = 1'b1;
    gcnt0 = 0;
    cyc();
    bus.rsp0_tready = 1'b0;
    repeat (8) cyc();
    chk("c_one_more_grant", gcnt0, 1);
    bus.req0_tvalid = 1'b0; bus.req1_tvalid = 1'b0;
    bus.rsp0_tready = 1'b1;
    wait_idle("c");

    // D: reset with reads in flight and responses buffered.
    bus.rsp0_tready = 1'b0; bus.rsp1_tready = 1'b0;
    bus.req0_tvalid = 1'b1; bus.req1_tvalid = 1'b1;
    repeat (4) cyc();
    reset_p = 1'b1;
    bus.req0_tvalid = 1'b0; bus.req1_tvalid = 1'b0;
    cyc();
    reset_p = 1'b0;
    @(negedge clk);
    chk("d_busy", bus.busy, 1'b0);
    chk("d_rsp0_tvalid", bus.rsp0_tvalid, 1'b0);
    chk("d_rsp1_tvalid", bus.rsp1_tvalid, 1'b0);
    cyc();
    bus.rsp0_tready = 1'b1; bus.rsp1_tready = 1'b1;
    addr0 = 8'h33; bus.req0_tdata = addr0; bus.req0_tvalid = 1'b1;
    lim0 = 1'b1; end0 = 8'h34;
    log0.delete();
    repeat (6) cyc();
    chk("d_after_count", log0.size(), 1);
    if (log0.size() != 0) chk("d_after_data", log0[0], 16'hA533);
    lim0 = 1'b0;

    // E: randomized traffic with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      reset_p         = ($urandom_range(0, 199) == 0);
      bus.req0_tvalid = ($urandom_range(0, 3) != 0);
      bus.req1_tvalid = ($urandom_range(0, 3) != 0);
      bus.rsp0_tready = ($urandom_range(0, 1) != 0);
      bus.rsp1_tready = ($urandom_range(0, 2) != 0);
      addr0 = 8'($urandom);
      addr1 = 8'($urandom);
      bus.req0_tdata = addr0;
      bus.req1_tdata = addr1;
      cyc();
    end
    reset_p = 1'b0;
    bus.req0_tvalid = 1'b0; bus.req1_tvalid = 1'b0;
    bus.rsp0_tready = 1'b1; bus.rsp1_tready = 1'b1;
    wait_idle("e");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
